// File: rtl/mor1kx_wb_commit_latte.sv
// mor1kx_wb_commit_latte
// Write-back commit stage sitting right after the RF write-back mux.
// Commits SR flag updates and the atomic reservation. Picks the winning
// write-back exception by priority and captures ESR/EPCR/EEAR. Then runs a
// small flush/redirect FSM that flushes the pipeline for one cycle and
// holds a fetch redirect (exception vector or l.rfe return) until fetch
// acknowledges it.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   padv_wb_i           write-back advance; wb_* inputs valid this cycle
//   pc_wb_i             PC of the write-back instruction
//   wb_delay_slot_i     instruction is in a delay slot
//   wb_*_set/clear_i    SR flag / carry / overflow / atomic updates
//   wb_except_*_i       exception causes, qualified by wb_excepts_en_i
//   wb_op_rfe_i         l.rfe in write-back
//   lsu_adr_i           faulting data address
//   fetch_ack_i         fetch accepted the redirect
//   sr_o, esr_o, epcr_o, eear_o   architectural registers
//   atomic_reserve_o    atomic reservation valid
//   pipeline_flush_o    one-cycle pipeline flush
//   redirect_o, redirect_adr_o    fetch redirect request and target
module mor1kx_wb_commit_latte #(
    parameter int                              OPTION_OPERAND_WIDTH  = 32,
    parameter logic [OPTION_OPERAND_WIDTH-1:0] OPTION_EXCEPTION_BASE = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            padv_wb_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] pc_wb_i,
    input  logic                            wb_delay_slot_i,
    input  logic                            wb_flag_set_i,
    input  logic                            wb_flag_clear_i,
    input  logic                            wb_carry_set_i,
    input  logic                            wb_carry_clear_i,
    input  logic                            wb_overflow_set_i,
    input  logic                            wb_overflow_clear_i,
    input  logic                            wb_atomic_flag_set_i,
    input  logic                            wb_atomic_flag_clear_i,
    input  logic                            wb_except_itlb_miss_i,
    input  logic                            wb_except_ipagefault_i,
    input  logic                            wb_except_ibus_err_i,
    input  logic                            wb_except_ibus_align_i,
    input  logic                            wb_except_illegal_i,
    input  logic                            wb_except_syscall_i,
    input  logic                            wb_except_trap_i,
    input  logic                            wb_except_dtlb_miss_i,
    input  logic                            wb_except_dpagefault_i,
    input  logic                            wb_except_align_i,
    input  logic                            wb_except_dbus_i,
    input  logic                            wb_excepts_en_i,
    input  logic                            wb_op_rfe_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_adr_i,
    input  logic                            fetch_ack_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] sr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] esr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] epcr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] eear_o,
    output logic                            atomic_reserve_o,
    output logic                            pipeline_flush_o,
    output logic                            redirect_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] redirect_adr_o
);

    localparam int W = OPTION_OPERAND_WIDTH;

    // SR bit positions
    localparam int SR_SM  = 0;
    localparam int SR_TEE = 1;
    localparam int SR_IEE = 2;
    localparam int SR_F   = 9;
    localparam int SR_CY  = 10;
    localparam int SR_OV  = 11;
    localparam int SR_DSX = 13;

    localparam logic [W-1:0] SR_RESET = W'(32'h8001);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        REDIRECT
    } state_t;

    state_t state, state_next;

    logic        exc;
    logic        exc_acc;
    logic        rfe_acc;
    logic [11:0] vec_offset;
    logic        data_cause;
    logic        sys_cause;
    logic [W-1:0] epcr_next;
    logic [W-1:0] eear_next;

    assign exc = wb_excepts_en_i &
                 (wb_except_itlb_miss_i  | wb_except_ipagefault_i |
                  wb_except_ibus_err_i   | wb_except_ibus_align_i |
                  wb_except_illegal_i    | wb_except_syscall_i    |
                  wb_except_trap_i       | wb_except_dtlb_miss_i  |
                  wb_except_dpagefault_i | wb_except_align_i      |
                  wb_except_dbus_i);

    // Exceptions and l.rfe are only taken while the FSM is idle; an
    // exception always beats an l.rfe in the same instruction.
    assign exc_acc = padv_wb_i & (state == IDLE) & exc;
    assign rfe_acc = padv_wb_i & (state == IDLE) & wb_op_rfe_i & ~exc;

    // Priority encoder: instruction-side causes first, then data-side.
    always_comb begin
        vec_offset = 12'h000;
        data_cause = 1'b0;
        sys_cause  = 1'b0;
        if (wb_except_itlb_miss_i)       vec_offset = 12'hA00;
        else if (wb_except_ipagefault_i) vec_offset = 12'h400;
        else if (wb_except_ibus_err_i)   vec_offset = 12'h200;
        else if (wb_except_ibus_align_i) vec_offset = 12'h600;
        else if (wb_except_illegal_i)    vec_offset = 12'h700;
        else if (wb_except_syscall_i) begin
            vec_offset = 12'hC00;
            sys_cause  = 1'b1;
        end else if (wb_except_trap_i) begin
            vec_offset = 12'hE00;
            sys_cause  = 1'b1;
        end else if (wb_except_dtlb_miss_i) begin
            vec_offset = 12'h900;
            data_cause = 1'b1;
        end else if (wb_except_dpagefault_i) begin
            vec_offset = 12'h300;
            data_cause = 1'b1;
        end else if (wb_except_align_i) begin
            vec_offset = 12'h600;
            data_cause = 1'b1;
        end else if (wb_except_dbus_i) begin
            vec_offset = 12'h200;
            data_cause = 1'b1;
        end
    end

    // Delay-slot exceptions restart at the branch; syscall/trap resume
    // after the excepting instruction.
    always_comb begin
        if (wb_delay_slot_i)
            epcr_next = pc_wb_i - W'(4);
        else if (sys_cause)
            epcr_next = pc_wb_i + W'(4);
        else
            epcr_next = pc_wb_i;
        eear_next = data_cause ? lsu_adr_i : pc_wb_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_o             <= SR_RESET;
            esr_o            <= '0;
            epcr_o           <= '0;
            eear_o           <= '0;
            redirect_adr_o   <= '0;
            atomic_reserve_o <= 1'b0;
        end else begin
            if (exc_acc) begin
                esr_o          <= sr_o;
                sr_o[SR_SM]    <= 1'b1;
                sr_o[SR_IEE]   <= 1'b0;
                sr_o[SR_TEE]   <= 1'b0;
                sr_o[SR_DSX]   <= wb_delay_slot_i;
                epcr_o         <= epcr_next;
                eear_o         <= eear_next;
                redirect_adr_o <= OPTION_EXCEPTION_BASE + {{(W-12){1'b0}}, vec_offset};
            end else if (rfe_acc) begin
                sr_o           <= esr_o;
                redirect_adr_o <= epcr_o;
            end else if (padv_wb_i && !exc) begin
                if (wb_flag_set_i)          sr_o[SR_F]  <= 1'b1;
                else if (wb_flag_clear_i)   sr_o[SR_F]  <= 1'b0;
                if (wb_carry_set_i)         sr_o[SR_CY] <= 1'b1;
                else if (wb_carry_clear_i)  sr_o[SR_CY] <= 1'b0;
                if (wb_overflow_set_i)      sr_o[SR_OV] <= 1'b1;
                else if (wb_overflow_clear_i) sr_o[SR_OV] <= 1'b0;
            end

            if (exc_acc)
                atomic_reserve_o <= 1'b0;
            else if (padv_wb_i && !exc) begin
                if (wb_atomic_flag_set_i)        atomic_reserve_o <= 1'b1;
                else if (wb_atomic_flag_clear_i) atomic_reserve_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next       = state;
        pipeline_flush_o = 1'b0;
        redirect_o       = 1'b0;
        case (state)
            IDLE: begin
                if (exc_acc || rfe_acc)
                    state_next = FLUSH;
            end
            FLUSH: begin
                pipeline_flush_o = 1'b1;
                state_next       = REDIRECT;
            end
            REDIRECT: begin
                redirect_o = 1'b1;
                if (fetch_ack_i)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/mor1kx_wb_commit_latte.md
Name: mor1kx_wb_commit_latte

Overview:
- Write-back commit stage directly downstream of the RF write-back mux.
- Consumes its registered flag, exception, RFE, PC and delay-slot outputs.
- Maintains the architectural SR, ESR, EPCR and EEAR registers and the atomic reservation.
- Arbitrates write-back exceptions by priority, then runs a flush/redirect FSM that drives the pipeline flush and the fetch redirect (exception vector or RFE return).

Parameters:
- OPTION_OPERAND_WIDTH, 32, width of PC, SR, ESR, EPCR, EEAR and addresses.
- OPTION_EXCEPTION_BASE, 32'h0, added to every vector offset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- padv_wb_i  in  1  write-back stage advance; wb_* inputs are valid in this cycle.
- pc_wb_i  in  OPTION_OPERAND_WIDTH  PC of the instruction in write-back.
- wb_delay_slot_i  in  1  instruction in write-back is in a delay slot.
- wb_flag_set_i, wb_flag_clear_i, wb_carry_set_i, wb_carry_clear_i, wb_overflow_set_i, wb_overflow_clear_i  in  1 each  SR flag updates.
- wb_atomic_flag_set_i, wb_atomic_flag_clear_i  in  1 each  atomic reservation updates.
- wb_except_itlb_miss_i, wb_except_ipagefault_i, wb_except_ibus_err_i, wb_except_ibus_align_i, wb_except_illegal_i, wb_except_syscall_i, wb_except_trap_i, wb_except_dtlb_miss_i, wb_except_dpagefault_i, wb_except_align_i, wb_except_dbus_i  in  1 each  exception causes.
- wb_excepts_en_i  in  1  qualifies all exception causes.
- wb_op_rfe_i  in  1  l.rfe in write-back.
- lsu_adr_i  in  OPTION_OPERAND_WIDTH  faulting data address.
- fetch_ack_i  in  1  fetch accepted the redirect.
- sr_o  out  OPTION_OPERAND_WIDTH  architectural SR.
- esr_o, epcr_o, eear_o  out  OPTION_OPERAND_WIDTH  exception registers.
- atomic_reserve_o  out  1  atomic reservation valid.
- pipeline_flush_o  out  1  flush the whole pipeline.
- redirect_o  out  1  fetch redirect request.
- redirect_adr_o  out  OPTION_OPERAND_WIDTH  redirect target.

Behaviour:
- Reset values:
  - sr_o = 32'h8001 (SM=1, FO=1, all other bits 0).
  - esr_o, epcr_o, eear_o, redirect_adr_o = 0.
  - atomic_reserve_o, pipeline_flush_o, redirect_o = 0.
  - FSM in IDLE.
- SR bit map: SM=0, TEE=1, IEE=2, F=9, CY=10, OV=11, DSX=13, FO=15.
- exc = wb_excepts_en_i & (OR of all cause inputs). exc and wb_op_rfe_i are sampled only when padv_wb_i=1 and the FSM is in IDLE.
- Flag commit (padv_wb_i=1, exc=0):
  - F <= 1 on flag_set, 0 on flag_clear; set wins if both are asserted.
  - CY and OV follow the same rule with their own set/clear inputs.
  - atomic_reserve_o follows the same rule; it is also cleared by any accepted exception.
  - With exc=1, the excepting instruction's flag updates are discarded.
- Priority and vector offset, highest first:
  - itlb 0xA00, ipagefault 0x400, ibus_err 0x200, ibus_align 0x600, illegal 0x700, syscall 0xC00, trap 0xE00, dtlb 0x900, dpagefault 0x300, align 0x600, dbus 0x200.
- Exception accept, in the same cycle:
  - esr <= SR.
  - SR[SM] <= 1; SR[IEE] <= 0; SR[TEE] <= 0; SR[DSX] <= wb_delay_slot_i.
- EPCR:
  - Delay slot: pc_wb-4.
  - Otherwise, syscall/trap winner: pc_wb+4.
  - Otherwise: pc_wb.
- EEAR:
  - Data-cause winner (dtlb, dpagefault, align, dbus): lsu_adr_i.
  - Otherwise: pc_wb.
- redirect_adr <= OPTION_EXCEPTION_BASE + offset.
- RFE accept (wb_op_rfe_i=1, exc=0): SR <= ESR; redirect_adr <= EPCR. exc has priority over RFE.
- FSM:
  - IDLE: on exc or RFE accept -> FLUSH.
  - FLUSH: pipeline_flush_o=1 for exactly one cycle -> REDIRECT.
  - REDIRECT: redirect_o=1 and redirect_adr_o held stable until the fetch_ack_i cycle -> IDLE, with redirect_o=0 the following cycle.
  - Latency: accept edge -> flush visible next cycle -> redirect the cycle after.
- New accepts are ignored while the FSM is not in IDLE.
- Arithmetic is modulo 2^OPTION_OPERAND_WIDTH; pc_wb 0 minus 4 wraps to 32'hFFFFFFFC.
- rst mid-sequence returns every output to its reset value on the next edge; no redirect is completed.

Test Plan:
- flag_set with padv_wb=1 -> sr_o[9]=1 next cycle; flag_set and flag_clear together -> F=1; carry_set -> sr_o[10]=1.
- illegal, pc_wb=0x1000, no delay slot -> esr=0x8001, epcr=0x1000, eear=0x1000, sr_o[0]=1; flush one cycle later; redirect_adr=0x700 held until fetch_ack.
- syscall in delay slot, pc_wb=0x2004 -> epcr=0x2000, sr_o[13]=1, redirect 0xC00.
- itlb_miss with dbus and wb_excepts_en_i=1, lsu_adr=0x40 -> vector 0xA00, eear=pc_wb; same cycle with wb_excepts_en_i=0 -> no flush, flags commit.
- RFE with esr=0x0205, epcr=0x3000 -> sr_o=0x0205, redirect 0x3000; RFE with illegal -> exception path wins.
- atomic_set, then dpagefault -> atomic_reserve_o 1 then 0; rst asserted during REDIRECT -> redirect_o=0 and sr_o=0x8001 after the edge.
